// File: rtl/buffer_load_writer_if.sv
// Bundle of command, read-stream and buffer-write signals for the load writer.
// The master side issues commands and beats. The slave side is the writer itself.
interface buffer_load_writer_if #(
    parameter int BUFFER_ADDR_WIDTH = 11,
    parameter int BUFFER_DATA_WIDTH = 512,
    parameter int LEN_WIDTH         = 12
);
    logic                         cmd_valid;
    logic                         cmd_ready;
    logic [BUFFER_ADDR_WIDTH-1:0] cmd_buf_addr;
    logic [LEN_WIDTH-1:0]         cmd_len;
    logic                         rd_data_valid;
    logic                         rd_data_ready;
    logic [BUFFER_DATA_WIDTH-1:0] rd_data;
    logic                         rd_data_last;
    logic                         load_write_addr_valid;
    logic [BUFFER_ADDR_WIDTH-1:0] load_write_addr;
    logic [BUFFER_DATA_WIDTH-1:0] load_write_data;
    logic                         load_done;
    logic                         load_err;
    logic                         busy;

    modport master (
        output cmd_valid, cmd_buf_addr, cmd_len, rd_data_valid, rd_data, rd_data_last,
        input  cmd_ready, rd_data_ready, load_write_addr_valid, load_write_addr,
               load_write_data, load_done, load_err, busy
    );

    modport slave (
        input  cmd_valid, cmd_buf_addr, cmd_len, rd_data_valid, rd_data, rd_data_last,
        output cmd_ready, rd_data_ready, load_write_addr_valid, load_write_addr,
               load_write_data, load_done, load_err, busy
    );
endinterface

// File: rtl/buffer_load_writer.sv
// Load-side write sequencer: takes one (address, length) command, then turns each
// accepted stream beat into a registered buffer write at consecutive addresses.
// It flags beats whose last marker disagrees with the command length.
module buffer_load_writer #(
    parameter int BUFFER_ADDR_WIDTH = 11,
    parameter int BUFFER_DATA_WIDTH = 512,
    parameter int LEN_WIDTH         = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    buffer_load_writer_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                       r_state;
    state_t                       w_next_state;
    logic [BUFFER_ADDR_WIDTH-1:0] r_cur_addr;
    logic [LEN_WIDTH-1:0]         r_remaining;
    logic                         w_cmd_acc;
    logic                         w_beat_acc;
    logic                         w_final;

    logic                         r_wr_valid_p1;
    logic [BUFFER_ADDR_WIDTH-1:0] r_wr_addr_p1;
    logic [BUFFER_DATA_WIDTH-1:0] r_wr_data_p1;
    logic                         r_err_p1;

    // A beat is misframed when its last marker does not match whether it is the final beat.
    function automatic logic frame_err(input logic last, input logic final_beat);
        return last ^ final_beat;
    endfunction

    assign w_cmd_acc  = bus.cmd_valid & bus.cmd_ready;
    assign w_beat_acc = bus.rd_data_valid & bus.rd_data_ready;
    assign w_final    = (r_remaining == LEN_WIDTH'(1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    // Next-state decode; beat counting follows cmd_len only, never the last marker.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_cmd_acc) w_next_state = (bus.cmd_len == '0) ? S_DONE : S_RUN;
            S_RUN:   if (w_beat_acc && w_final) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Handshake and status outputs decoded from state only.
    always_comb begin
        bus.cmd_ready     = (r_state == S_IDLE);
        bus.rd_data_ready = (r_state == S_RUN);
        bus.busy          = (r_state != S_IDLE);
        bus.load_done     = (r_state == S_DONE);
    end

    // Address and beat counters; the address wraps naturally at the buffer depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur_addr  <= '0;
            r_remaining <= '0;
        end else if (w_cmd_acc) begin
            r_cur_addr  <= bus.cmd_buf_addr;
            r_remaining <= bus.cmd_len;
        end else if (w_beat_acc) begin
            r_cur_addr  <= r_cur_addr + BUFFER_ADDR_WIDTH'(1);
            r_remaining <= r_remaining - LEN_WIDTH'(1);
        end
    end

    // Stage p1: one registered write per accepted beat, zeroed on idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_valid_p1 <= 1'b0;
            r_wr_addr_p1  <= '0;
            r_wr_data_p1  <= '0;
            r_err_p1      <= 1'b0;
        end else begin
            r_wr_valid_p1 <= w_beat_acc;
            r_wr_addr_p1  <= w_beat_acc ? r_cur_addr : '0;
            r_wr_data_p1  <= w_beat_acc ? bus.rd_data : '0;
            r_err_p1      <= w_beat_acc & frame_err(bus.rd_data_last, w_final);
        end
    end

    assign bus.load_write_addr_valid = r_wr_valid_p1;
    assign bus.load_write_addr       = r_wr_addr_p1;
    assign bus.load_write_data       = r_wr_data_p1;
    assign bus.load_err              = r_err_p1;
endmodule

// File: tb/tb_buffer_load_writer.sv
// Bench for buffer_load_writer: table of load commands plus a mid-transfer reset sequence,
// with expected writes queued at beat accept and compared when the DUT strobes.
module tb_buffer_load_writer;
    logic clk;
    logic rst_n;

    buffer_load_writer_if #(.BUFFER_ADDR_WIDTH(11), .BUFFER_DATA_WIDTH(512), .LEN_WIDTH(12)) bus ();

    buffer_load_writer #(.BUFFER_ADDR_WIDTH(11), .BUFFER_DATA_WIDTH(512), .LEN_WIDTH(12)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         valid;
        logic [10:0]  addr;
        logic [511:0] data;
        logic         err;
        logic         done;
    } exp_t;

    typedef struct {
        logic [10:0] addr;
        int          len;
        logic [15:0] vpat;
        logic [15:0] lastpat;
        int          exp_writes;
        int          exp_errs;
    } vec_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   n_wr  = 0;
    int   n_err = 0;
    int   n_done = 0;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, want);
        end
    endtask

    // Monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && (bus.load_write_addr_valid || bus.load_done || bus.load_err)) begin
            if (bus.load_write_addr_valid) n_wr++;
            if (bus.load_err) n_err++;
            if (bus.load_done) n_done++;
            if (sb.size() == 0) begin
                chk("unexpected_strobe", 512'(bus.load_write_addr_valid), 512'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("wr_valid", 512'(bus.load_write_addr_valid), 512'(e.valid));
                chk("wr_addr",  512'(bus.load_write_addr), 512'(e.addr));
                chk("wr_data",  bus.load_write_data, e.data);
                chk("load_err", 512'(bus.load_err), 512'(e.err));
                chk("load_done", 512'(bus.load_done), 512'(e.done));
            end
        end
    end

    task automatic wait_cmd_ready();
        int c;
        c = 0;
        @(negedge clk);
        while (!bus.cmd_ready && c < 20) begin
            @(negedge clk);
            c++;
        end
        if (!bus.cmd_ready) chk("cmd_ready_timeout", 512'(bus.cmd_ready), 512'(1));
    endtask

    task automatic run_cmd(input logic [10:0] a, input int len,
                           input logic [15:0] vp, input logic [15:0] lp);
        int b;
        int c;
        exp_t e;
        logic [511:0] d;
        wait_cmd_ready();
        bus.cmd_valid    = 1'b1;
        bus.cmd_buf_addr = a;
        bus.cmd_len      = 12'(len);
        if (len == 0) begin
            e.valid = 1'b0; e.addr = '0; e.data = '0; e.err = 1'b0; e.done = 1'b1;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        if (len == 0) begin
            @(negedge clk);
            chk("len0_cmd_ready", 512'(bus.cmd_ready), 512'(0));
            chk("len0_rd_ready",  512'(bus.rd_data_ready), 512'(0));
            chk("len0_busy",      512'(bus.busy), 512'(1));
        end else begin
            b = 0;
            c = 0;
            while (b < len && c < 200) begin
                d = {16{$urandom()}};
                bus.rd_data_valid = vp[c % 16];
                bus.rd_data       = d;
                bus.rd_data_last  = lp[b % 16];
                @(negedge clk);
                if (bus.rd_data_valid && bus.rd_data_ready) begin
                    e.valid = 1'b1;
                    e.addr  = a + 11'(b);
                    e.data  = d;
                    e.done  = (b == len - 1);
                    e.err   = (bus.rd_data_last != (b == len - 1));
                    sb.push_back(e);
                    b++;
                end
                @(posedge clk);
                #1;
                c++;
            end
            bus.rd_data_valid = 1'b0;
            bus.rd_data_last  = 1'b0;
            if (b < len) chk("beat_timeout", 512'(b), 512'(len));
        end
        c = 0;
        while (sb.size() != 0 && c < 20) begin
            @(negedge clk);
            c++;
        end
        chk("drain", 512'(sb.size()), 512'(0));
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{11'h010, 4, 16'hFFFF, 16'h0008, 4, 0};
        vecs[1] = '{11'h7FE, 4, 16'hFFFF, 16'h0008, 4, 0};
        vecs[2] = '{11'h020, 6, 16'hFFCD, 16'h0020, 6, 0};
        vecs[3] = '{11'h030, 0, 16'hFFFF, 16'h0000, 0, 0};
        vecs[4] = '{11'h040, 3, 16'hFFFF, 16'h0002, 3, 2};
        vecs[5] = '{11'h050, 3, 16'hFFFF, 16'h0000, 3, 1};
        vecs[6] = '{11'h060, 3, 16'hFFFF, 16'h0004, 3, 0};

        rst_n             = 1'b0;
        bus.cmd_valid     = 1'b0;
        bus.cmd_buf_addr  = '0;
        bus.cmd_len       = '0;
        bus.rd_data_valid = 1'b0;
        bus.rd_data       = '0;
        bus.rd_data_last  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 512'(bus.cmd_ready), 512'(1));
        chk("rst_rd_ready",  512'(bus.rd_data_ready), 512'(0));
        chk("rst_busy",      512'(bus.busy), 512'(0));
        chk("rst_wr_valid",  512'(bus.load_write_addr_valid), 512'(0));
        chk("rst_wr_addr",   512'(bus.load_write_addr), 512'(0));
        chk("rst_wr_data",   bus.load_write_data, 512'(0));
        chk("rst_done",      512'(bus.load_done), 512'(0));
        chk("rst_err",       512'(bus.load_err), 512'(0));
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            n_wr = 0; n_err = 0; n_done = 0;
            run_cmd(vecs[i].addr, vecs[i].len, vecs[i].vpat, vecs[i].lastpat);
            @(negedge clk);
            chk($sformatf("v%0d_writes", i), 512'(n_wr), 512'(vecs[i].exp_writes));
            chk($sformatf("v%0d_errs", i),   512'(n_err), 512'(vecs[i].exp_errs));
            chk($sformatf("v%0d_done", i),   512'(n_done), 512'(1));
        end

        // Mid-transfer reset: len=8, reset while the third write strobe is on the bus.
        begin
            exp_t e;
            logic [511:0] d;
            n_wr = 0; n_err = 0; n_done = 0;
            wait_cmd_ready();
            bus.cmd_valid    = 1'b1;
            bus.cmd_buf_addr = 11'h200;
            bus.cmd_len      = 12'd8;
            @(posedge clk);
            #1;
            bus.cmd_valid = 1'b0;
            for (int k = 0; k < 3; k++) begin
                d = {16{$urandom()}};
                bus.rd_data_valid = 1'b1;
                bus.rd_data       = d;
                bus.rd_data_last  = 1'b0;
                @(negedge clk);
                chk("rstseq_rd_ready", 512'(bus.rd_data_ready), 512'(1));
                e.valid = 1'b1; e.addr = 11'h200 + 11'(k); e.data = d; e.err = 1'b0; e.done = 1'b0;
                sb.push_back(e);
                @(posedge clk);
                #1;
            end
            bus.rd_data_valid = 1'b0;
            chk("pre_reset_strobe", 512'(bus.load_write_addr_valid), 512'(1));
            #1;
            rst_n = 1'b0;
            sb.delete();
            #1;
            chk("async_wr_valid", 512'(bus.load_write_addr_valid), 512'(0));
            chk("async_wr_addr",  512'(bus.load_write_addr), 512'(0));
            chk("async_wr_data",  bus.load_write_data, 512'(0));
            chk("async_busy",     512'(bus.busy), 512'(0));
            chk("async_done",     512'(bus.load_done), 512'(0));
            chk("async_cmd_ready", 512'(bus.cmd_ready), 512'(1));
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            chk("post_rst_busy",   512'(bus.busy), 512'(0));
            chk("post_rst_done",   512'(bus.load_done), 512'(0));
            chk("rstseq_writes",   512'(n_wr), 512'(2));
            chk("rstseq_no_done",  512'(n_done), 512'(0));
        end

        n_wr = 0; n_err = 0; n_done = 0;
        run_cmd(11'h100, 1, 16'hFFFF, 16'h0001);
        @(negedge clk);
        chk("after_rst_writes", 512'(n_wr), 512'(1));
        chk("after_rst_done",   512'(n_done), 512'(1));
        chk("after_rst_errs",   512'(n_err), 512'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "timeout");
    end
endmodule
